// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - shared types and helpers for the register-file writeback arbiter
package regfile_arb_pkg;

  localparam int NUM_REGS = 16;
  localparam int REG_W    = 16;

  typedef struct packed {
    logic [3:0]  addr;
    logic        wide;
    logic [31:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {IDLE, WAIT, FORCE} arb_state_e;

  // Register bits touched by a write: the destination, plus R0 for a wide result.
  function automatic logic [NUM_REGS-1:0] reg_mask(input logic [3:0] addr, input logic wide);
    logic [NUM_REGS-1:0] m;
    m       = '0;
    m[addr] = 1'b1;
    m[0]    = m[0] | wide;
    return m;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - MDU result buffer; a pushed entry reaches the head only after the clock edge
module wb_fifo
  import regfile_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_req_t          push_data,
  input  logic             pop,
  output wb_req_t          head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head = mem[rd_ptr];

  // Entry storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; the caller never pushes when full or pops when empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - write-port arbiter between pipeline writeback and MDU; optional WB_BYPASS_EN
module regfile_wb_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                halt_sys,
  input  logic                pipe_we,
  input  logic [3:0]          pipe_addr,
  input  logic [REG_W-1:0]    pipe_data,
  input  logic                mdu_valid,
  output logic                mdu_ready,
  input  logic [3:0]          mdu_addr,
  input  logic                mdu_wide,
  input  logic [31:0]         mdu_data,
  input  logic                mdu_issue,
  input  logic [3:0]          mdu_issue_addr,
  input  logic                mdu_issue_wide,
  output logic                stall_pipe,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                rf_write_en,
  output logic                rf_R0_en,
  output logic [3:0]          rf_write_address,
  output logic [31:0]         rf_write_data
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WC_W  = $clog2(STARVE_LIMIT + 1);

  arb_state_e          state, state_next;
  logic [WC_W-1:0]     wait_cnt, wait_cnt_next;
  logic [CNT_W-1:0]    count;
  wb_req_t             head, in_req, grant_req;
  logic                push, pop, grant_pipe, grant_mdu, bypass, last;
  logic [NUM_REGS-1:0] busy_set, busy_clr;

  assign in_req    = {mdu_addr, mdu_wide, mdu_data};
  assign mdu_ready = !halt_sys && (count < CNT_W'(DEPTH));
  assign last      = (count == CNT_W'(1)) && !push;
  assign grant_req = bypass ? in_req : head;

  wb_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_req),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  // Arbitration: pipeline first, MDU head when the pipeline is idle or has starved it too long.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    push          = mdu_valid && mdu_ready;
    pop           = 1'b0;
    grant_pipe    = 1'b0;
    grant_mdu     = 1'b0;
    bypass        = 1'b0;
    stall_pipe    = 1'b0;
    if (!halt_sys) begin
      case (state)
        IDLE: begin
          grant_pipe = pipe_we;
`ifdef WB_BYPASS_EN
          if (!pipe_we && mdu_valid) begin
            bypass    = 1'b1;
            grant_mdu = 1'b1;
            push      = 1'b0;
          end
`endif
          if (push) state_next = WAIT;
        end
        WAIT: begin
          if (!pipe_we) begin
            grant_mdu     = 1'b1;
            pop           = 1'b1;
            wait_cnt_next = '0;
            state_next    = last ? IDLE : WAIT;
          end else begin
            grant_pipe    = 1'b1;
            wait_cnt_next = wait_cnt + 1'b1;
            if (wait_cnt_next >= WC_W'(STARVE_LIMIT - 1)) state_next = FORCE;
          end
        end
        FORCE: begin
          stall_pipe    = 1'b1;
          grant_mdu     = 1'b1;
          pop           = 1'b1;
          wait_cnt_next = '0;
          state_next    = last ? IDLE : WAIT;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Scoreboard updates: new reservations win over a clearing grant of the same register.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (mdu_issue && !halt_sys) busy_set = reg_mask(mdu_issue_addr, mdu_issue_wide);
    if (grant_mdu)              busy_clr = reg_mask(grant_req.addr, grant_req.wide);
  end

  // State, starvation counter and scoreboard registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      busy_mask <= '0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      busy_mask <= (busy_mask & ~busy_clr) | busy_set;
    end
  end

  // Registered write port: a grant in one cycle drives the register file the next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_write_en      <= 1'b0;
      rf_R0_en         <= 1'b0;
      rf_write_address <= '0;
      rf_write_data    <= '0;
    end else begin
      rf_write_en <= grant_pipe || grant_mdu;
      if (grant_mdu) begin
        rf_R0_en         <= grant_req.wide;
        rf_write_address <= grant_req.addr;
        rf_write_data    <= grant_req.data;
      end else if (grant_pipe) begin
        rf_R0_en         <= 1'b0;
        rf_write_address <= pipe_addr;
        rf_write_data    <= {16'h0, pipe_data};
      end else begin
        rf_R0_en         <= 1'b0;
      end
    end
  end

  // The hazard unit must never let the pipeline overwrite a register the MDU still owns.
  a_no_busy_write: assert property (@(posedge clk) disable iff (!rst)
    (pipe_we && !halt_sys) |-> !busy_mask[pipe_addr]);

endmodule
